// File: rtl/i2c_bus_arbiter_if.sv
// Requester and I2C master engine signals shared by the bus arbiter.
// master: arbiter side, slave: requesters plus master engine.
interface i2c_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*8-1:0]      req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [7:0]                resp_rdata;
    logic                      resp_err;
    logic                      m_start;
    logic                      m_rw;
    logic [ADDR_W-1:0]         m_addr;
    logic [7:0]                m_wdata;
    logic                      m_abort;
    logic                      m_busy;
    logic [7:0]                m_rdata;
    logic                      m_ack_err;

    modport master (
        input  req, req_rw, req_addr, req_wdata,
        input  m_busy, m_rdata, m_ack_err,
        output gnt, done, resp_rdata, resp_err,
        output m_start, m_rw, m_addr, m_wdata, m_abort
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata,
        output m_busy, m_rdata, m_ack_err,
        input  gnt, done, resp_rdata, resp_err,
        input  m_start, m_rw, m_addr, m_wdata, m_abort
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master among requesters.
// Optional watchdog/abort: define I2C_BUS_ARBITER_TIMEOUT_EN.
module i2c_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 1024
) (
    input logic               clk,
    input logic               reset,
    i2c_bus_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [IW-1:0]      r_ptr, w_ptr_n;
    logic [IW-1:0]      r_win, w_win_n;
    logic [IW-1:0]      w_sel;
    logic               w_any;
    logic               w_to;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
    logic [NUM_REQ-1:0] r_done, w_done_n;
    logic [7:0]         r_rdata, w_rdata_n;
    logic               r_err, w_err_n;
    logic               r_start, w_start_n;
    logic               r_rw, w_rw_n;
    logic [ADDR_W-1:0]  r_addr, w_addr_n;
    logic [7:0]         r_wdata, w_wdata_n;
    logic               r_abort, w_abort_n;

    // Search from ptr; descending loop lets the nearest requester win.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_sel = IW'((int'(r_ptr) + k) % NUM_REQ);
                w_any = 1'b1;
            end
        end
    end

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          w_wait;

    assign w_wait = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    assign w_to   = w_wait && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_n != r_state) begin
            r_cnt <= '0;
        end else if (w_wait) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT != 0);
    assign w_to        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any) w_state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.m_busy) w_state_n = WAIT_DONE;
                else if (w_to)  w_state_n = RESP;
            end
            WAIT_DONE: begin
                if (!bus.m_busy) w_state_n = RESP;
                else if (w_to)   w_state_n = RESP;
            end
            RESP: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt_n   = r_gnt;
        w_done_n  = '0;
        w_rdata_n = r_rdata;
        w_err_n   = r_err;
        w_start_n = r_start;
        w_rw_n    = r_rw;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_abort_n = 1'b0;
        w_win_n   = r_win;
        w_ptr_n   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_n        = '0;
                    w_gnt_n[w_sel] = 1'b1;
                    w_win_n        = w_sel;
                    w_start_n      = 1'b1;
                    w_rw_n         = bus.req_rw[w_sel];
                    w_addr_n  = bus.req_addr[w_sel*ADDR_W +: ADDR_W];
                    w_wdata_n = bus.req_wdata[w_sel*8 +: 8];
                end
            end
            WAIT_BUSY: begin
                if (bus.m_busy) begin
                    w_start_n = 1'b0;
                end else if (w_to) begin
                    w_start_n = 1'b0;
                    w_abort_n = 1'b1;
                    w_rdata_n = 8'h00;
                    w_err_n   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.m_busy) begin
                    w_rdata_n = bus.m_rdata;
                    w_err_n   = bus.m_ack_err;
                end else if (w_to) begin
                    w_abort_n = 1'b1;
                    w_rdata_n = 8'h00;
                    w_err_n   = 1'b1;
                end
            end
            RESP: begin
                w_done_n = r_gnt;
                w_gnt_n  = '0;
                w_ptr_n  = (r_win == IW'(NUM_REQ - 1)) ?
                           '0 : r_win + IW'(1);
            end
            default: begin
                w_gnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_abort <= 1'b0;
            r_win   <= '0;
            r_ptr   <= '0;
        end else begin
            r_gnt   <= w_gnt_n;
            r_done  <= w_done_n;
            r_rdata <= w_rdata_n;
            r_err   <= w_err_n;
            r_start <= w_start_n;
            r_rw    <= w_rw_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_abort <= w_abort_n;
            r_win   <= w_win_n;
            r_ptr   <= w_ptr_n;
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.done       = r_done;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.m_start    = r_start;
    assign bus.m_rw       = r_rw;
    assign bus.m_addr     = r_addr;
    assign bus.m_wdata    = r_wdata;
    assign bus.m_abort    = r_abort;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: master engine model, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_i2c_bus_arbiter;
    localparam int NR = 4;
    localparam int AW = 3;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

    i2c_bus_arbiter #(
        .NUM_REQ(NR),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    int         mm_delay = 1;
    int         mm_len   = 4;
    logic [7:0] mm_rdata = 8'h00;
    logic       mm_nack  = 1'b0;

    int order_q[$];
    int last_len = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int rr(input logic [NR-1:0] r, input int p);
        int w;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            if (w < 0 && r[(p + k) % NR]) w = (p + k) % NR;
        end
        return w;
    endfunction

    // Reference model: one transaction record, advanced once per cycle
    // using the inputs the DUT sampled at the preceding rising edge.
    bit            a_act, a_seen, a_fell;
    int            a_win, a_ptr, a_tcnt;
    logic [NR-1:0] e_gnt, e_done;
    logic          e_start, e_rw, e_err, e_abort;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wd, e_rd;
    int            mp, mc, mb, cur_len;

    initial begin
        bus.m_busy    = 1'b0;
        bus.m_rdata   = 8'h00;
        bus.m_ack_err = 1'b0;
        a_act = 0; a_seen = 0; a_fell = 0;
        a_win = 0; a_ptr = 0; a_tcnt = 0;
        e_rw = 0; e_addr = '0; e_wd = '0; e_rd = '0; e_err = 0;
        mp = 0; mc = 0; mb = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            e_done  = '0;
            e_abort = 1'b0;
            if (reset) begin
                a_act = 0; a_seen = 0; a_fell = 0; a_ptr = 0;
                e_rw = 0; e_addr = '0; e_wd = '0;
                e_rd = '0; e_err = 0;
            end else if (!a_act) begin
                if (|bus.req) begin
                    a_win  = rr(bus.req, a_ptr);
                    a_act  = 1; a_seen = 0; a_fell = 0; a_tcnt = 0;
                    e_rw   = bus.req_rw[a_win];
                    e_addr = bus.req_addr[a_win*AW +: AW];
                    e_wd   = bus.req_wdata[a_win*8 +: 8];
                    order_q.push_back(a_win);
                end
            end else if (!a_seen) begin
                if (bus.m_busy) begin
                    a_seen = 1; a_tcnt = 0;
                end else begin
                    a_tcnt++;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
                    if (a_tcnt == TO) begin
                        a_seen = 1; a_fell = 1; e_abort = 1;
                        e_rd = 8'h00; e_err = 1;
                    end
`endif
                end
            end else if (!a_fell) begin
                if (!bus.m_busy) begin
                    a_fell = 1;
                    e_rd   = bus.m_rdata;
                    e_err  = bus.m_ack_err;
                end else begin
                    a_tcnt++;
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
                    if (a_tcnt == TO) begin
                        a_fell = 1; e_abort = 1;
                        e_rd = 8'h00; e_err = 1;
                    end
`endif
                end
            end else begin
                e_done = NR'(1) << a_win;
                a_act  = 0;
                a_ptr  = (a_win + 1) % NR;
            end
            e_gnt   = a_act ? (NR'(1) << a_win) : '0;
            e_start = a_act && !a_seen;
            chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
            chk("gnt", bus.gnt, e_gnt);
            chk("done", bus.done, e_done);
            chk("m_start", bus.m_start, e_start);
            chk("m_abort", bus.m_abort, e_abort);
            chk("m_rw", bus.m_rw, e_rw);
            chk("m_addr", bus.m_addr, e_addr);
            chk("m_wdata", bus.m_wdata, e_wd);
            if (reset || e_done != '0) begin
                chk("resp_rdata", bus.resp_rdata, e_rd);
                chk("resp_err", bus.resp_err, e_err);
            end
            if (bus.m_start) begin
                cur_len++;
            end else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len  = 0;
            end
            // Master engine model: busy mm_delay cycles after start seen.
            if (reset) begin
                mp = 0;
                bus.m_busy = 1'b0;
            end else begin
                case (mp)
                    0: if (bus.m_start) begin
                        mc = 1;
                        if (mc >= mm_delay) begin
                            bus.m_busy = 1'b1; mb = 0; mp = 2;
                        end else begin
                            mp = 1;
                        end
                    end
                    1: begin
                        mc++;
                        if (mc >= mm_delay) begin
                            bus.m_busy = 1'b1; mb = 0; mp = 2;
                        end
                    end
                    default: begin
                        mb++;
                        if (mb >= mm_len) begin
                            bus.m_busy    = 1'b0;
                            bus.m_rdata   = mm_rdata;
                            bus.m_ack_err = mm_nack;
                            mp = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [NR-1:0] d,
                             output logic [7:0] rd, output logic er);
        bit found;
        found = 0;
        d = '0; rd = '0; er = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                found = 1;
                d  = bus.done;
                rd = bus.resp_rdata;
                er = bus.resp_err;
            end
        end
        chk("done_within_budget", 32'(found), 1);
        #1;
    endtask

    logic [NR-1:0] d;
    logic [7:0]    rd;
    logic          er;

    initial begin
        bus.req = '0; bus.req_rw = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        #1 reset = 1'b1;
        tick(); tick();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_start", bus.m_start, 0);
        chk("rst_abort", bus.m_abort, 0);
        chk("rst_err", bus.resp_err, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        reset = 1'b0;
        tick();

        mm_delay = 1; mm_len = 40; mm_rdata = 8'h11; mm_nack = 0;
        bus.req_addr[0 +: AW]  = 3'd5;
        bus.req_wdata[0 +: 8]  = 8'hA5;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("wr_start", bus.m_start, 1);
        chk("wr_gnt", bus.gnt, 4'b0001);
        chk("wr_addr", bus.m_addr, 5);
        chk("wr_wdata", bus.m_wdata, 8'hA5);
        #1;
        wait_done(d, rd, er);
        chk("wr_done", d, 4'b0001);
        chk("wr_err", er, 0);
        bus.req = '0;
        tick();

        mm_len = 5; mm_rdata = 8'h3C; mm_nack = 1;
        bus.req_rw = 4'b0100;
        bus.req_addr[2*AW +: AW] = 3'd6;
        bus.req = 4'b0100;
        wait_done(d, rd, er);
        chk("rd_done", d, 4'b0100);
        chk("rd_rdata", rd, 8'h3C);
        chk("rd_err", er, 1);
        bus.req = '0; mm_nack = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        mm_len = 3;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW] = AW'(i + 1);
            bus.req_wdata[i*8 +: 8]  = 8'(8'h10 + i);
        end
        bus.req_rw = 4'b1010;
        order_q.delete();
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_done(d, rd, er);
            chk("rr_done", d, 32'(1) << (t % NR));
        end
        bus.req = '0;
        tick(); tick();
        chk("rr_count", order_q.size(), 5);
        chk("rr_first", order_q[0], 0);
        chk("rr_second", order_q[1], 1);
        chk("rr_third", order_q[2], 2);
        chk("rr_fourth", order_q[3], 3);
        chk("rr_wrap", order_q[4], 0);

        mm_delay = 7; mm_len = 4; mm_rdata = 8'h5A;
        bus.req = 4'b0010;
        wait_done(d, rd, er);
        chk("slow_done", d, 4'b0010);
        chk("slow_rdata", rd, 8'h5A);
        bus.req = '0;
        tick();
        chk("slow_start_len", last_len, 7);

        mm_delay = 1; mm_len = 50;
        bus.req = 4'b1000;
        repeat (10) tick();
        chk("mid_in_busy", bus.m_busy, 1);
        reset   = 1'b1;
        bus.req = '0;
        #1;
        chk("mid_gnt", bus.gnt, 0);
        chk("mid_start", bus.m_start, 0);
        chk("mid_rw", bus.m_rw, 0);
        chk("mid_addr", bus.m_addr, 0);
        chk("mid_wdata", bus.m_wdata, 0);
        chk("mid_rdata", bus.resp_rdata, 0);
        tick(); tick();
        mm_len  = 4;
        bus.req = 4'b1010;
        reset   = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", bus.gnt, 4'b0010);
        #1;
        wait_done(d, rd, er);
        chk("post_rst_done", d, 4'b0010);
        bus.req = '0;
        tick();

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
        begin
            bit ab;
            ab = 0;
            mm_delay = 100000;
            bus.req  = 4'b0001;
            for (int i = 0; i < 40 && !ab; i++) begin
                @(negedge clk);
                if (bus.m_abort) ab = 1;
            end
            #1;
            chk("to_abort_seen", 32'(ab), 1);
            wait_done(d, rd, er);
            chk("to_done", d, 4'b0001);
            chk("to_err", er, 1);
            chk("to_rdata", rd, 0);
            bus.req = '0;
            tick(); tick();
            chk("to_idle_gnt", bus.gnt, 0);
        end
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
